// File: rtl/idelay_tap_picker.sv
// Post-sweep IDELAY calibration: finds the widest run of low-error taps,
// picks its centre tap and loads it through the DLY_LD/DLY_CNT interface.
module idelay_tap_picker #(
  parameter int COUNT_WIDTH   = 24,
  parameter int DELAY_TAPS    = 32,
  parameter int ERR_THRESHOLD = 0,
  parameter int MIN_WINDOW    = 3
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                I_STB,
  input  logic [COUNT_WIDTH*DELAY_TAPS-1:0]   I_DAT,
  output logic                                DLY_LD,
  output logic [$clog2(DELAY_TAPS)-1:0]       DLY_CNT,
  output logic                                BUSY,
  output logic                                O_VALID,
  output logic [$clog2(DELAY_TAPS)-1:0]       O_TAP,
  output logic [$clog2(DELAY_TAPS):0]         O_WIDTH,
  output logic                                O_FAIL
);

  localparam int TW = $clog2(DELAY_TAPS);
  localparam int LW = TW + 1;
  localparam int DW = COUNT_WIDTH * DELAY_TAPS;

  localparam logic [COUNT_WIDTH-1:0] THRESH  = COUNT_WIDTH'(ERR_THRESHOLD);
  localparam logic [LW-1:0]          MIN_LEN = LW'(MIN_WINDOW);
  localparam logic [TW-1:0]          LAST_K  = TW'(DELAY_TAPS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, LOAD, DONE} state_t;

  state_t           stateQ;
  logic [DW-1:0]    dataQ;
  logic [TW-1:0]    kQ;
  logic [TW-1:0]    runStartQ;
  logic [TW-1:0]    bestStartQ;
  logic [LW-1:0]    runLenQ;
  logic [LW-1:0]    bestLenQ;
  logic             failQ;
  logic             dlyLdQ;
  logic             oValidQ;
  logic             oFailQ;
  logic [TW-1:0]    oTapQ;
  logic [LW-1:0]    oWidthQ;

  logic [COUNT_WIDTH-1:0] curCount;
  logic                   good;
  logic                   lastTap;
  logic [LW-1:0]          runLenD;
  logic [TW-1:0]          runStartD;
  logic [LW-1:0]          candLen;
  logic [LW-1:0]          bestLenD;
  logic [TW-1:0]          bestStartD;
  logic                   decideFail;
  logic [LW-1:0]          halfLen;
  logic [TW-1:0]          centreTap;

  // The latched vector shifts left once per SCAN cycle, so tap k is always in the MS chunk.
  always_comb begin
    curCount   = dataQ[DW-1 -: COUNT_WIDTH];
    good       = (curCount <= THRESH);
    lastTap    = (kQ == LAST_K);
    runLenD    = good ? (runLenQ + 1'b1) : '0;
    runStartD  = (good && (runLenQ == '0)) ? kQ : runStartQ;
    candLen    = good ? runLenD : runLenQ;
    bestLenD   = bestLenQ;
    bestStartD = bestStartQ;
    if ((!good || lastTap) && (candLen > bestLenQ)) begin
      bestLenD   = candLen;
      bestStartD = runStartD;
    end
    decideFail = (bestLenQ < MIN_LEN);
    halfLen    = (bestLenQ - 1'b1) >> 1;
    centreTap  = bestStartQ + halfLen[TW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ     <= IDLE;
      kQ         <= '0;
      runStartQ  <= '0;
      bestStartQ <= '0;
      runLenQ    <= '0;
      bestLenQ   <= '0;
      failQ      <= 1'b0;
      dlyLdQ     <= 1'b0;
      oValidQ    <= 1'b0;
      oFailQ     <= 1'b0;
      oTapQ      <= '0;
      oWidthQ    <= '0;
    end else begin
      dlyLdQ  <= 1'b0;
      oValidQ <= 1'b0;
      oFailQ  <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (I_STB) begin
            dataQ      <= I_DAT;
            kQ         <= '0;
            runStartQ  <= '0;
            runLenQ    <= '0;
            bestLenQ   <= '0;
            bestStartQ <= '0;
            stateQ     <= SCAN;
          end
        end
        SCAN: begin
          dataQ      <= dataQ << COUNT_WIDTH;
          kQ         <= kQ + 1'b1;
          runLenQ    <= runLenD;
          runStartQ  <= runStartD;
          bestLenQ   <= bestLenD;
          bestStartQ <= bestStartD;
          if (lastTap) begin
            stateQ <= DECIDE;
          end
        end
        DECIDE: begin
          failQ   <= decideFail;
          oWidthQ <= bestLenQ;
          if (!decideFail) begin
            oTapQ <= centreTap;
          end
          dlyLdQ  <= !decideFail;
          stateQ  <= LOAD;
        end
        LOAD: begin
          oValidQ <= 1'b1;
          oFailQ  <= failQ;
          stateQ  <= DONE;
        end
        DONE: begin
          stateQ <= IDLE;
        end
        default: begin
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign DLY_LD  = dlyLdQ;
  assign DLY_CNT = oTapQ;
  assign BUSY    = (stateQ != IDLE);
  assign O_VALID = oValidQ;
  assign O_TAP   = oTapQ;
  assign O_WIDTH = oWidthQ;
  assign O_FAIL  = oFailQ;

endmodule

// File: tb/tb_idelay_tap_picker.sv
// Self-checking bench for idelay_tap_picker: table vectors plus random vectors
// scored through a queue, with corner sequences for ignored strobes and reset.
module tb_idelay_tap_picker;

  localparam int CW = 24;
  localparam int NT = 32;
  localparam int TW = 5;
  localparam int LW = 6;
  localparam int DW = CW * NT;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_STB;
  logic [DW-1:0] I_DAT;
  logic          DLY_LD, BUSY, O_VALID, O_FAIL;
  logic [TW-1:0] DLY_CNT, O_TAP;
  logic [LW-1:0] O_WIDTH;
  logic          DLY_LD2, BUSY2, O_VALID2, O_FAIL2;
  logic [TW-1:0] DLY_CNT2, O_TAP2;
  logic [LW-1:0] O_WIDTH2;

  idelay_tap_picker #(.COUNT_WIDTH(CW), .DELAY_TAPS(NT), .ERR_THRESHOLD(0), .MIN_WINDOW(3)) dut (
    .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_DAT(I_DAT),
    .DLY_LD(DLY_LD), .DLY_CNT(DLY_CNT), .BUSY(BUSY), .O_VALID(O_VALID),
    .O_TAP(O_TAP), .O_WIDTH(O_WIDTH), .O_FAIL(O_FAIL)
  );

  idelay_tap_picker #(.COUNT_WIDTH(CW), .DELAY_TAPS(NT), .ERR_THRESHOLD(5), .MIN_WINDOW(3)) dut2 (
    .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_DAT(I_DAT),
    .DLY_LD(DLY_LD2), .DLY_CNT(DLY_CNT2), .BUSY(BUSY2), .O_VALID(O_VALID2),
    .O_TAP(O_TAP2), .O_WIDTH(O_WIDTH2), .O_FAIL(O_FAIL2)
  );

  always #5 CLK = ~CLK;

  int cycleCnt = 0;
  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  int compared   = 0;
  int mismatched = 0;
  int lastTap    = 0;

  typedef struct {
    logic [DW-1:0] dat;
    int            expTap;
    int            expWidth;
    bit            expFail;
    bit            chk2;
    int            expTap2;
    int            expWidth2;
  } vec_t;

  typedef struct {
    int tap;
    int width;
    bit fail;
    int stbCycle;
    bit chk2;
    int tap2;
    int width2;
  } exp_t;

  exp_t sbQ[$];
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input int req);
    compared++;
    if (act !== 32'(req)) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] makeVec(input int lo1, input int hi1, input int lo2, input int hi2,
                                           input logic [CW-1:0] goodVal, input logic [CW-1:0] badVal);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NT; k++) begin
      d[CW*(NT-k)-1 -: CW] = ((k >= lo1 && k <= hi1) || (k >= lo2 && k <= hi2)) ? goodVal : badVal;
    end
    return d;
  endfunction

  // Brute force: longest good run starting at each tap, earliest strict maximum wins.
  task automatic modelPick(input logic [DW-1:0] d, input int thr, output int width, output int start);
    logic [CW-1:0] c;
    int len;
    width = 0;
    start = 0;
    for (int s = 0; s < NT; s++) begin
      len = 0;
      for (int k = s; k < NT; k++) begin
        c = d[CW*(NT-k)-1 -: CW];
        if (32'(c) > 32'(thr)) break;
        len++;
      end
      if (len > width) begin
        width = len;
        start = s;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.fail   = v.expFail;
    e.width  = v.expWidth;
    e.tap    = v.expFail ? lastTap : v.expTap;
    e.chk2   = v.chk2;
    e.tap2   = v.expTap2;
    e.width2 = v.expWidth2;
    if (!v.expFail) lastTap = v.expTap;
    @(posedge CLK);
    #1;
    I_DAT      = v.dat;
    I_STB      = 1'b1;
    e.stbCycle = cycleCnt;
    sbQ.push_back(e);
    @(posedge CLK);
    #1;
    I_STB = 1'b0;
  endtask

  task automatic checkOutput(input int extraAt, input logic [DW-1:0] extraDat);
    exp_t          e;
    int            validCount = 0;
    int            ldCount = 0;
    int            failCount = 0;
    int            ld2Count = 0;
    int            validCycle = -1;
    int            ldCycle = -1;
    logic [TW-1:0] ldCnt = '0;
    logic [TW-1:0] ld2Cnt = '0;
    logic [TW-1:0] gotTap = '0;
    logic [TW-1:0] gotTap2 = '0;
    logic [LW-1:0] gotWidth = '0;
    logic [LW-1:0] gotWidth2 = '0;
    logic          gotFail = 1'b0;
    logic          gotFail2 = 1'b0;
    logic          busyEarly = 1'b0;
    logic          busyLate = 1'b1;
    e = sbQ.pop_front();
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (extraAt > 0 && cycleCnt == e.stbCycle + extraAt) begin
        I_DAT = extraDat;
        I_STB = 1'b1;
      end else begin
        I_STB = 1'b0;
      end
      if (cycleCnt == e.stbCycle + 1)  busyEarly = BUSY;
      if (cycleCnt == e.stbCycle + 37) busyLate  = BUSY;
      if (DLY_LD) begin
        ldCount++;
        ldCycle = cycleCnt;
        ldCnt   = DLY_CNT;
      end
      if (O_FAIL) failCount++;
      if (O_VALID) begin
        validCount++;
        validCycle = cycleCnt;
        gotTap     = O_TAP;
        gotWidth   = O_WIDTH;
        gotFail    = O_FAIL;
      end
      if (DLY_LD2) begin
        ld2Count++;
        ld2Cnt = DLY_CNT2;
      end
      if (O_VALID2) begin
        gotTap2   = O_TAP2;
        gotWidth2 = O_WIDTH2;
        gotFail2  = O_FAIL2;
      end
    end
    check("busy_after_stb", 32'(busyEarly), 1);
    check("busy_after_done", 32'(busyLate), 0);
    check("valid_count", 32'(validCount), 1);
    check("valid_cycle", 32'(validCycle), e.stbCycle + NT + 3);
    check("o_tap", 32'(gotTap), e.tap);
    check("o_width", 32'(gotWidth), e.width);
    check("o_fail", 32'(gotFail), e.fail ? 1 : 0);
    check("fail_pulses", 32'(failCount), e.fail ? 1 : 0);
    check("ld_pulses", 32'(ldCount), e.fail ? 0 : 1);
    if (!e.fail) begin
      check("ld_cycle", 32'(ldCycle), e.stbCycle + NT + 2);
      check("dly_cnt", 32'(ldCnt), e.tap);
    end
    if (e.chk2) begin
      check("thr5_tap", 32'(gotTap2), e.tap2);
      check("thr5_width", 32'(gotWidth2), e.width2);
      check("thr5_fail", 32'(gotFail2), 0);
      check("thr5_ld", 32'(ld2Count), 1);
      check("thr5_dly_cnt", 32'(ld2Cnt), e.tap2);
    end
  endtask

  task automatic resetMidScan();
    int stb;
    int ldCount = 0;
    int validCount = 0;
    @(posedge CLK);
    #1;
    I_DAT = makeVec(0, 31, -1, -2, 24'd0, 24'd0);
    I_STB = 1'b1;
    stb   = cycleCnt;
    @(posedge CLK);
    #1;
    I_STB = 1'b0;
    while (cycleCnt < stb + 10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    lastTap = 0;
    check("rst_mid_busy", 32'(BUSY), 0);
    check("rst_mid_tap", 32'(O_TAP), 0);
    check("rst_mid_width", 32'(O_WIDTH), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DLY_LD) ldCount++;
      if (O_VALID) validCount++;
    end
    check("rst_mid_no_ld", 32'(ldCount), 0);
    check("rst_mid_no_valid", 32'(validCount), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   w;
    int   s;
    int   r;

    // dat, tap, width, fail, chk2, tap2, width2
    tbl[0] = '{makeVec(0, 31, -1, -2, 24'd0, 24'd0),            15, 32, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{makeVec(10, 20, -1, -2, 24'd0, 24'd1000),        15, 11, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{makeVec(2, 5, 20, 23, 24'd0, 24'd5),              3,  4, 1'b0, 1'b1, 15, 32};
    tbl[3] = '{makeVec(28, 31, -1, -2, 24'd0, 24'd9),           29,  4, 1'b0, 1'b0, 0, 0};
    tbl[4] = '{makeVec(0, 1, -1, -2, 24'd0, 24'd7),              0,  2, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{makeVec(7, 9, -1, -2, 24'd0, 24'hFFFFFF),         8,  3, 1'b0, 1'b0, 0, 0};
    tbl[6] = '{makeVec(-1, -2, -1, -2, 24'd0, 24'd1),            0,  0, 1'b1, 1'b0, 0, 0};
    tbl[7] = '{makeVec(0, 3, 6, 12, 24'd0, 24'd1),               9,  7, 1'b0, 1'b0, 0, 0};

    RST   = 1'b1;
    I_STB = 1'b0;
    I_DAT = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_dly_ld", 32'(DLY_LD), 0);
    check("rst_dly_cnt", 32'(DLY_CNT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_valid", 32'(O_VALID), 0);
    check("rst_tap", 32'(O_TAP), 0);
    check("rst_width", 32'(O_WIDTH), 0);
    check("rst_fail", 32'(O_FAIL), 0);
    check("rst_busy_thr5", 32'(BUSY2), 0);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(0, '0);
    end

    // Second strobe mid-scan carries an all-bad vector; it must not disturb the run.
    applyStimulus(tbl[1]);
    checkOutput(5, makeVec(-1, -2, -1, -2, 24'd0, 24'd50));

    // A strobe during DONE must not start a new run.
    applyStimulus(tbl[3]);
    checkOutput(NT + 3, makeVec(0, 31, -1, -2, 24'd0, 24'd0));

    resetMidScan();
    applyStimulus(tbl[5]);
    checkOutput(0, '0);

    for (int n = 0; n < 6; n++) begin
      v.dat = '0;
      for (int k = 0; k < NT; k++) begin
        r = $urandom_range(0, 9);
        v.dat[CW*(NT-k)-1 -: CW] = (r < 7) ? 24'd0 : ((r == 7) ? 24'd1 : 24'($urandom));
      end
      modelPick(v.dat, 0, w, s);
      v.expWidth = w;
      v.expFail  = (w < 3);
      v.expTap   = s + (w - 1) / 2;
      modelPick(v.dat, 5, w, s);
      v.chk2      = (w >= 3);
      v.expWidth2 = w;
      v.expTap2   = s + (w - 1) / 2;
      applyStimulus(v);
      checkOutput(0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
